// File: rtl/alu_pkg.sv
// Shared ALU definitions: modulo-unit FSM states and ALU op-code constants.
package alu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } mod_state_e;

  localparam logic [2:0] ALU_OP_AND = 3'b000;
  localparam logic [2:0] ALU_OP_OR  = 3'b001;
  localparam logic [2:0] ALU_OP_XOR = 3'b010;
  localparam logic [2:0] ALU_OP_MOD = 3'b111;

endpackage

// File: rtl/mod_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// conditionally subtract the divisor.
module mod_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] rem_sh;

  always_comb begin
    rem_sh   = {rem, dvd_msb};
    q_bit    = 1'b0;
    rem_next = rem_sh[WIDTH-1:0];
    if (rem_sh >= {1'b0, div}) begin
      q_bit    = 1'b1;
      // true difference is below div, so the low WIDTH bits are exact
      rem_next = rem_sh[WIDTH-1:0] - div;
    end
  end

endmodule

// File: rtl/mod_32bit.sv
// Sequential unsigned A mod B (and A / B), one quotient bit per clock.
// Optional build macro MOD_EARLY_EXIT_EN finishes in one cycle when A < B.
//
// state | meaning
// IDLE  | waiting for start; done may pulse here for one cycle
// CALC  | shift-subtract iterations (or one-cycle zero/early exit)
module mod_32bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] quotient,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  mod_state_e       state, state_next;
  logic [WIDTH-1:0] dvd, div, rem, q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic             accept, finish, zero_exit, early_exit;

  mod_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .div      (div),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    // div is fixed for the whole operation, so checking it every CALC cycle
    // only ever fires on the first one
    zero_exit  = (state == CALC) && (div == '0);
`ifdef MOD_EARLY_EXIT_EN
    early_exit = (state == CALC) && (cnt == '0) && (div != '0) && (dvd < div);
`else
    early_exit = 1'b0;
`endif
    finish     = (state == CALC) && (zero_exit || early_exit || (cnt == LAST));
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_next = CALC;
      end
      CALC: begin
        if (finish) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd      <= '0;
      div      <= '0;
      rem      <= '0;
      q        <= '0;
      cnt      <= '0;
      result   <= '0;
      quotient <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dvd      <= A;
        div      <= B;
        rem      <= '0;
        q        <= '0;
        cnt      <= '0;
        div_zero <= 1'b0;
      end else if (state == CALC) begin
        if (zero_exit) begin
          result   <= dvd;
          quotient <= '1;
          div_zero <= 1'b1;
          done     <= 1'b1;
        end else if (early_exit) begin
          result   <= dvd;
          quotient <= '0;
          done     <= 1'b1;
        end else begin
          rem <= rem_next;
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          q   <= {q[WIDTH-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            result   <= rem_next;
            quotient <= {q[WIDTH-2:0], q_bit};
            done     <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_32bit.sv
// Directed self-checking bench for mod_32bit with hand-computed vectors.
module tb_mod_32bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A, B;
  logic [31:0] result, quotient;
  logic        busy, done, div_zero;

  int errors = 0;
  int checks = 0;
  int lat;

`ifdef MOD_EARLY_EXIT_EN
  localparam int LAT_LT = 1;
`else
  localparam int LAT_LT = 32;
`endif

  mod_32bit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .result   (result),
    .quotient (quotient),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request at the next edge, then count cycles until done.
  // inj_at > 0 re-asserts start (A=9, B=2) that many cycles into the op.
  task automatic run_op(input logic [31:0] a_in, input logic [31:0] b_in,
                        input int inj_at, output int latency);
    A = a_in; B = b_in; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    latency = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == inj_at + 1 && inj_at > 0) begin
        A = 32'd9; B = 32'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (done) begin
        latency = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    tick(); tick();
    check("rst_result", result, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_div_zero", {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(32'd100, 32'd7, 0, lat);
    check("100_7_latency", lat, 32'd32);
    check("100_7_result", result, 32'd2);
    check("100_7_quotient", quotient, 32'd14);
    check("100_7_div_zero", {31'd0, div_zero}, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("result_held", result, 32'd2);

    run_op(32'd5, 32'd0, 0, lat);
    check("dz_latency", lat, 32'd1);
    check("dz_result", result, 32'd5);
    check("dz_quotient", quotient, 32'hFFFF_FFFF);
    check("dz_flag", {31'd0, div_zero}, 32'd1);
    tick();
    check("dz_flag_held", {31'd0, div_zero}, 32'd1);

    run_op(32'hFFFF_FFFF, 32'd1, 0, lat);
    check("max_1_latency", lat, 32'd32);
    check("max_1_result", result, 32'd0);
    check("max_1_quotient", quotient, 32'hFFFF_FFFF);
    check("max_1_dz_cleared", {31'd0, div_zero}, 32'd0);

    run_op(32'hFFFF_FFFF, 32'h8000_0000, 0, lat);
    check("max_msb_latency", lat, 32'd32);
    check("max_msb_result", result, 32'h7FFF_FFFF);
    check("max_msb_quotient", quotient, 32'd1);

    run_op(32'd3, 32'd10, 0, lat);
    check("lt_latency", lat, LAT_LT);
    check("lt_result", result, 32'd3);
    check("lt_quotient", quotient, 32'd0);

    run_op(32'd100, 32'd7, 10, lat);
    check("ignore_latency", lat, 32'd32);
    check("ignore_result", result, 32'd2);
    check("ignore_quotient", quotient, 32'd14);
    // still in the done cycle: this start must be accepted
    run_op(32'd9, 32'd2, 0, lat);
    check("b2b_latency", lat, 32'd32);
    check("b2b_result", result, 32'd1);
    check("b2b_quotient", quotient, 32'd4);

    A = 32'd100; B = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 15; c++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_div_zero", {31'd0, div_zero}, 32'd0);
    tick();
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        tick();
        seen += int'(done);
      end
      check("midrst_no_done", seen, 32'd0);
    end
    run_op(32'd50, 32'd6, 0, lat);
    check("post_rst_latency", lat, 32'd32);
    check("post_rst_result", result, 32'd2);
    check("post_rst_quotient", quotient, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
